// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared types and constants for the sequential multiply/divide unit.
//   state_t        FSM state encoding (IDLE, MUL, DIV, DONE)
//   OP_MUL/OP_DIV  operation-select encodings for OpE
//   STEPS          number of datapath steps per operation (32)
//   neg_if()       conditional two's-complement negation helper
package muldiv_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned STEPS = 32;
  localparam int unsigned CNT_W = 5;

  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  function automatic logic [XLEN-1:0] neg_if(input logic en, input logic [XLEN-1:0] v);
    return en ? (~v + XLEN'(1)) : v;
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one combinational iteration of the multiply/divide datapath.
//   op       OP_MUL = radix-2 shift-add step, OP_DIV = restoring-division step
//   hi, lo   current accumulator halves (MUL: partial product / multiplier,
//            DIV: partial remainder / dividend-then-quotient)
//   b        multiplicand or divisor
//   hi_next, lo_next  accumulator after this step
module muldiv_step
  import muldiv_pkg::*;
(
  input  logic            op,
  input  logic [XLEN-1:0] hi,
  input  logic [XLEN-1:0] lo,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] hi_next,
  output logic [XLEN-1:0] lo_next
);

  logic [XLEN:0]   sum;
  logic [XLEN:0]   shifted;
  logic [XLEN-1:0] diff;
  logic            ge;

  always_comb begin
    // MUL: add multiplicand when the multiplier LSB is set, then shift right with carry.
    sum     = {1'b0, hi} + (lo[0] ? {1'b0, b} : '0);
    // DIV: partial remainder stays below the divisor, so the shifted value fits in XLEN+1 bits.
    shifted = {hi, lo[XLEN-1]};
    diff    = XLEN'(shifted - {1'b0, b});
    ge      = (shifted >= {1'b0, b});
    if (op == OP_DIV) begin
      hi_next = ge ? diff : shifted[XLEN-1:0];
      lo_next = {lo[XLEN-2:0], ge};
    end else begin
      hi_next = sum[XLEN:1];
      lo_next = {sum[0], lo[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// muldiv_seq: sequential 32x32 multiplier / 32-bit restoring divider, 32 steps per op.
//   clk, reset      clock, synchronous active-high reset
//   StartE, OpE     start request, operation (0 = MUL, 1 = DIV)
//   SignedE         signed operands (only honoured when MULDIV_SIGNED_EN is defined)
//   FlushE          abort the in-flight operation
//   SrcAE, SrcBE    multiplicand/dividend, multiplier/divisor
//   StallMD         combinational pipeline stall while an operation is being accepted or run
//   DoneM           one-cycle completion pulse
//   ResultLo/Hi     product low/high or quotient/remainder
//   DivZero         divisor was zero on the completed DIV
// Build option: define MULDIV_SIGNED_EN to enable signed operation.
module muldiv_seq
  import muldiv_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        StartE,
  input  logic        OpE,
  input  logic        SignedE,
  input  logic        FlushE,
  input  logic [31:0] SrcAE,
  input  logic [31:0] SrcBE,
  output logic        StallMD,
  output logic        DoneM,
  output logic [31:0] ResultLo,
  output logic [31:0] ResultHi,
  output logic        DivZero
);

  state_t            state, state_n;
  logic [CNT_W-1:0]  cnt;
  logic [XLEN-1:0]   acc_hi, acc_lo, opb;
  logic              op_r, neg_a, neg_b;
  logic [XLEN-1:0]   step_hi, step_lo;
  logic              sgn, start_acc, dz_start;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   res_lo_n, res_hi_n;
  logic              res_dz_n;

`ifdef MULDIV_SIGNED_EN
  assign sgn = SignedE;
`else
  logic unused_signed;
  assign unused_signed = SignedE;
  assign sgn           = 1'b0;
`endif

  // Operands are held as magnitudes; signs are reapplied when the result is captured.
  assign a_mag = neg_if(sgn & SrcAE[XLEN-1], SrcAE);
  assign b_mag = neg_if(sgn & SrcBE[XLEN-1], SrcBE);

  muldiv_step u_step (
    .op      (op_r),
    .hi      (acc_hi),
    .lo      (acc_lo),
    .b       (opb),
    .hi_next (step_hi),
    .lo_next (step_lo)
  );

  // Next-state and control outputs.
  always_comb begin
    state_n   = state;
    start_acc = 1'b0;
    StallMD   = 1'b0;
    DoneM     = 1'b0;
    dz_start  = (OpE == OP_DIV) && (SrcBE == '0);
    case (state)
      S_IDLE: begin
        StallMD   = StartE;
        start_acc = StartE;
      end
      S_MUL, S_DIV: begin
        StallMD = 1'b1;
        if (FlushE)          state_n = S_IDLE;
        else if (cnt == '0)  state_n = S_DONE;
      end
      S_DONE: begin
        DoneM = 1'b1;
        if (FlushE)       state_n = S_IDLE;
        else if (StartE)  start_acc = 1'b1;
        else              state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
    if (start_acc) begin
      if (dz_start)              state_n = S_DONE;
      else if (OpE == OP_DIV)    state_n = S_DIV;
      else                       state_n = S_MUL;
    end
    if (reset) StallMD = 1'b0;
  end

  // Result values captured on entry to DONE (divide-by-zero bypasses the datapath).
  always_comb begin
    prod = {step_hi, step_lo};
    if (neg_a ^ neg_b) prod = ~prod + (2*XLEN)'(1);
    res_dz_n = 1'b0;
    if (start_acc) begin
      res_lo_n = '1;
      res_hi_n = SrcAE;
      res_dz_n = 1'b1;
    end else if (op_r == OP_MUL) begin
      res_lo_n = prod[XLEN-1:0];
      res_hi_n = prod[2*XLEN-1:XLEN];
    end else begin
      res_lo_n = neg_if(neg_a ^ neg_b, step_lo);
      res_hi_n = neg_if(neg_a, step_hi);
    end
  end

  // State, operand, counter and result registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      cnt      <= '0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      opb      <= '0;
      op_r     <= OP_MUL;
      neg_a    <= 1'b0;
      neg_b    <= 1'b0;
      ResultLo <= '0;
      ResultHi <= '0;
      DivZero  <= 1'b0;
    end else begin
      state <= state_n;
      if (start_acc) begin
        op_r   <= OpE;
        neg_a  <= sgn & SrcAE[XLEN-1];
        neg_b  <= sgn & SrcBE[XLEN-1];
        acc_hi <= '0;
        acc_lo <= a_mag;
        opb    <= b_mag;
        cnt    <= CNT_W'(STEPS - 1);
      end else if (state == S_MUL || state == S_DIV) begin
        acc_hi <= step_hi;
        acc_lo <= step_lo;
        if (cnt != '0) cnt <= cnt - CNT_W'(1);
      end
      if (state_n == S_DONE) begin
        ResultLo <= res_lo_n;
        ResultHi <= res_hi_n;
        DivZero  <= res_dz_n;
      end
    end
  end

endmodule

// File: doc/muldiv_seq.md
MULDIV_SEQ -- requirements
Module: muldiv_seq

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-002 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-003 SHALL have port StartE, input, 1, execute-stage request to begin a multi-cycle operation.
REQ-004 SHALL have port OpE, input, 1, operation select: 0 = MUL (32x32->64), 1 = DIV (quotient/remainder).
REQ-005 SHALL have port SignedE, input, 1, signed-operand select (see REQ-030).
REQ-006 SHALL have port FlushE, input, 1, abort the in-flight operation.
REQ-007 SHALL have port SrcAE, input, 32, multiplicand / dividend.
REQ-008 SHALL have port SrcBE, input, 32, multiplier / divisor.
REQ-009 SHALL have port StallMD, output, 1, pipeline stall to hazard unit while busy.
REQ-010 SHALL have port DoneM, output, 1, one-cycle completion pulse.
REQ-011 SHALL have port ResultLo, output, 32, product[31:0] or quotient.
REQ-012 SHALL have port ResultHi, output, 32, product[63:32] or remainder.
REQ-013 SHALL have port DivZero, output, 1, set with DoneM when a DIV had divisor 0.

Function
REQ-014 SHALL implement FSM states IDLE, MUL, DIV, DONE.
REQ-015 IDLE: StartE=1 latches SrcAE, SrcBE, OpE, SignedE, loads counter = 31, and moves to MUL (OpE=0) or DIV (OpE=1); otherwise stays in IDLE.
REQ-016 StartE SHALL be sampled only in IDLE and DONE; StartE in MUL or DIV is ignored.
REQ-017 MUL: one shift-add step per cycle (unsigned radix-2); after the step with counter = 0 go to DONE; 32 cycles in MUL.
REQ-018 DIV: one restoring-division step per cycle; after the step with counter = 0 go to DONE; 32 cycles in DIV.
REQ-019 DIV with divisor 0 SHALL go from IDLE directly to DONE with quotient 0xFFFFFFFF, remainder = dividend, DivZero=1.
REQ-020 StallMD SHALL be 1 combinationally in the StartE cycle in IDLE and in every MUL/DIV cycle; 0 in DONE and otherwise in IDLE.
REQ-021 DONE: DoneM=1 for exactly one cycle; next state IDLE, or MUL/DIV directly if StartE=1 (back-to-back, REQ-015 latch rules apply).
REQ-022 ResultLo/ResultHi/DivZero SHALL update only on entry to DONE and hold until the next entry to DONE.
REQ-023 Total latency, start-accept edge to DoneM: 33 cycles for MUL/DIV; 1 cycle for divide-by-zero.
REQ-024 FlushE=1 in MUL, DIV or DONE SHALL force IDLE on the next edge, with no DoneM and results unchanged; FlushE has priority over StartE.
REQ-025 Counter SHALL be 5 bits, decrement by one per step; no wrap reachable.

Reset
REQ-026 reset SHALL force state IDLE, counter 0, StallMD=0, DoneM=0, ResultLo=0, ResultHi=0, DivZero=0, and all operand registers to 0.
REQ-027 reset SHALL take priority over FlushE and StartE; reset mid-operation discards the operation with no DoneM.

Configuration
REQ-028 SHALL define macro MULDIV_SIGNED_EN.
REQ-029 Without the macro, SignedE SHALL be ignored and all operations are unsigned.
REQ-030 With the macro, SignedE=1 SHALL convert operands to magnitude on latch and negate results on entry to DONE: product negative iff signs differ; quotient negative iff signs differ; remainder takes the dividend's sign. Latency is unchanged.

Structure
REQ-031 SHALL place the FSM state enum, the OP_MUL/OP_DIV encodings and the step-count constant 32 in shared package muldiv_pkg.
REQ-032 SHALL isolate the one-step datapath (shift-add / restore-subtract) in sub-module muldiv_step; the FSM and registers stay in muldiv_seq.

Verification
REQ-033 MUL 0x0000FFFF x 0x00010001 unsigned -> DoneM 33 cycles after start, ResultHi=0x00000000, ResultLo=0xFFFFFFFF.
REQ-034 DIV 100 / 7 -> ResultLo=14, ResultHi=2, DivZero=0; StallMD=1 from the start cycle through the last DIV cycle.
REQ-035 DIV 0x12345678 / 0 -> DoneM on the next cycle, ResultLo=0xFFFFFFFF, ResultHi=0x12345678, DivZero=1.
REQ-036 FlushE at cycle 10 of a MUL -> IDLE, no DoneM, prior results held; a new start then completes normally.
REQ-037 With MULDIV_SIGNED_EN: signed DIV -7 / 2 -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF; signed MUL -1 x -1 -> ResultHi:Lo = 0x0000000000000001.
REQ-038 Back-to-back: StartE held in DONE -> next operation accepted with no IDLE cycle; reset pulsed mid-DIV -> all outputs 0 on the next cycle.
